mvu_pe_acc: RTL and testbench
=============================

// Module: mvu_pe_acc
// PURPOSE
// - Consumer of the PE adder-tree sum. Accumulates SF successive per-cycle partial sums
//   (one per synapse fold) into one PE output.
// - Hands the result downstream over a valid/ready handshake.
// - Output register is separate from the accumulator, so the next fold group accumulates
//   while the previous result waits.
// PARAMETERS
// - SF       4  partial sums per output (synapse fold count), >= 1
// - TDstI    4  width of incoming adder-tree sum
// - TAcc     8  accumulator/output width, >= TDstI
// - SIGNED   1  1: in_add/out_acc two's complement; 0: unsigned
// PORTS
// - clock    in   1      rising-edge clock
// - reset    in   1      asynchronous, active-high reset
// - in_add   in   TDstI  partial sum from adder tree
// - in_v     in   1      in_add valid
// - in_rdy   out  1      accumulator can accept in_add this cycle
// - clear    in   1      discard partial accumulation (sync)
// - out_acc  out  TAcc   completed accumulation
// - out_v    out  1      out_acc valid
// - out_rdy  in   1      downstream accepts out_acc
// - out_sat  out  1      out_acc was saturated (tied 0 when feature compiled out)
// BEHAVIOUR
// - Reset (async, any cycle): acc=0, cnt=0, out_acc=0, out_v=0, out_sat=0; partial sum lost.
// - Accept = in_v && in_rdy.
//   in_rdy = !(cnt==SF-1 && out_v && !out_rdy): stall only on a group's last input while
//   the output is occupied. in_rdy is combinational from out_v/out_rdy/cnt.
// - Extension: in_add is sign-extended to TAcc if SIGNED, else zero-extended.
// - On accept:
//   - sum = (cnt==0 ? 0 : acc) + ext(in_add), modulo 2^TAcc.
//   - cnt < SF-1: acc<=sum, cnt<=cnt+1.
//   - cnt == SF-1: out_acc<=sum, out_v<=1, cnt<=0, acc<=0.
//   - SF=1: every accept completes.
// - Latency: out_v rises the cycle after the last accepted input of a group.
// - out_v clears on out_v && out_rdy unless a new completion occurs that same cycle.
//   In that case out_v stays 1 and out_acc takes the new sum (back-to-back, no bubble).
// - out_acc/out_sat hold stable while out_v && !out_rdy.
// - clear: cnt<=0, acc<=0; out_acc/out_v untouched.
//   - clear with accept in the same cycle: in_add becomes the first element of a new group,
//     so cnt<=1 (SF=1: it completes).
// - No input while !in_v: state holds; gaps between inputs are allowed anywhere.
// CONFIGURATION
// - MVU_PE_ACC_SAT_EN defined: each add saturates instead of wrapping.
//   - SIGNED=1 clamps to [-2^(TAcc-1), 2^(TAcc-1)-1]; SIGNED=0 clamps to 2^TAcc-1.
//   - Sticky per-group saturation flag is cleared at group start/clear and copied to
//     out_sat with out_acc.
// - Undefined: modulo-2^TAcc wrap, out_sat constant 0.
// TESTING (SF=4, TDstI=4, TAcc=8, SIGNED=1 unless stated)
// - 1 Basic: in_add 1,2,3,4 on consecutive cycles, out_rdy=1 -> out_v high the cycle
//     after the 4th accept, out_acc=8'd10, in_rdy stays 1.
// - 2 Signed: in_add 4'hF x4 -> out_acc=8'hFC (-4); with SIGNED=0 -> 8'd60.
// - 3 Backpressure: out_rdy=0; groups {1,2,3,4} then {1,1,1,1} -> in_rdy low on the 2nd
//     group's 4th input, out_acc holds 10. Raise out_rdy -> 4th accepted, next out_acc=4,
//     no loss/dup.
// - 4 Clear: accept 5,5, pulse clear, then 1,1,1,1 -> out_acc=4.
//     Clear coincident with in_add=2 then 1,1,1 -> out_acc=5.
// - 5 Overflow (TAcc=5): 7 x4 -> out_acc=5'b11100, out_sat=0.
//     With MVU_PE_ACC_SAT_EN -> out_acc=5'd15, out_sat=1.
// - 6 Reset mid-group: accept 3,3, assert reset asynchronously mid-cycle -> out_v=0
//     immediately. After release, 1,2,3,4 -> out_acc=10.

Source files
------------

// File: rtl/mvu_pe_acc.sv
// PE output accumulator: sums SF adder-tree partial sums per output and hands the result off over valid/ready.
// Define MVU_PE_ACC_SAT_EN to make every add saturate and report it on out_sat; otherwise adds wrap.
module mvu_pe_acc #(
  parameter int SF     = 4,
  parameter int TDstI  = 4,
  parameter int TAcc   = 8,
  parameter int SIGNED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [TDstI-1:0] in_add,
  input  logic             in_v,
  output logic             in_rdy,
  input  logic             clear,
  output logic [TAcc-1:0]  out_acc,
  output logic             out_v,
  input  logic             out_rdy,
  output logic             out_sat
);

  localparam int            CW   = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CW-1:0] LAST = CW'(SF - 1);

  logic [CW-1:0]   cnt, cnt_eff;
  logic [TAcc-1:0] acc, ext, base, sum;
  logic            fire, first, last;

  always_comb begin
    ext = '0;
    ext[TDstI-1:0] = in_add;
    if (SIGNED != 0)
      for (int i = TDstI; i < TAcc; i++) ext[i] = in_add[TDstI-1];
  end

  // Only a group's final input needs the output slot, so only that one can stall.
  assign in_rdy  = !(cnt == LAST && out_v && !out_rdy);
  assign fire    = in_v && in_rdy;
  // A clear in the same cycle as an accept makes in_add the first element of a fresh group.
  assign cnt_eff = clear ? '0 : cnt;
  assign first   = (cnt_eff == '0);
  assign last    = (cnt_eff == LAST);
  assign base    = first ? '0 : acc;

`ifdef MVU_PE_ACC_SAT_EN
  logic [TAcc:0] raw;
  logic          ovf, sat_r, sat_nx, out_sat_r;

  always_comb begin
    raw = {1'b0, base} + {1'b0, ext};
    sum = raw[TAcc-1:0];
    ovf = 1'b0;
    if (SIGNED != 0) begin
      if (base[TAcc-1] == ext[TAcc-1] && raw[TAcc-1] != base[TAcc-1]) begin
        ovf = 1'b1;
        sum = base[TAcc-1] ? {1'b1, {(TAcc-1){1'b0}}} : {1'b0, {(TAcc-1){1'b1}}};
      end
    end else if (raw[TAcc]) begin
      ovf = 1'b1;
      sum = '1;
    end
  end

  assign sat_nx = (first ? 1'b0 : sat_r) | ovf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sat_r     <= 1'b0;
      out_sat_r <= 1'b0;
    end else if (fire) begin
      if (last) begin
        out_sat_r <= sat_nx;
        sat_r     <= 1'b0;
      end else begin
        sat_r     <= sat_nx;
      end
    end else if (clear) begin
      sat_r <= 1'b0;
    end
  end

  assign out_sat = out_sat_r;
`else
  assign sum     = base + ext;
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      out_acc <= '0;
      out_v   <= 1'b0;
    end else begin
      if (out_v && out_rdy) out_v <= 1'b0;
      if (fire) begin
        if (last) begin
          // Overrides the handshake clear above: back-to-back results with no bubble.
          out_acc <= sum;
          out_v   <= 1'b1;
          cnt     <= '0;
          acc     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt_eff + 1'b1;
        end
      end else if (clear) begin
        cnt <= '0;
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Bench for mvu_pe_acc: three configurations share one stimulus bus, checked by a group-level model.
module tb_mvu_pe_acc;

  localparam int SF = 4;
`ifdef MVU_PE_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock, reset, in_v, clear, out_rdy;
  logic [3:0] in_add;
  logic [2:0] rdy_w, ov_w, sat_w;
  logic [7:0] acc_s8, acc_u8;
  logic [4:0] acc_s5;

  int checks = 0;
  int errors = 0;

  mvu_pe_acc #(.SF(SF), .TDstI(4), .TAcc(8), .SIGNED(1)) u_s8 (
    .clock(clock), .reset(reset), .in_add(in_add), .in_v(in_v), .in_rdy(rdy_w[0]),
    .clear(clear), .out_acc(acc_s8), .out_v(ov_w[0]), .out_rdy(out_rdy), .out_sat(sat_w[0]));
  mvu_pe_acc #(.SF(SF), .TDstI(4), .TAcc(8), .SIGNED(0)) u_u8 (
    .clock(clock), .reset(reset), .in_add(in_add), .in_v(in_v), .in_rdy(rdy_w[1]),
    .clear(clear), .out_acc(acc_u8), .out_v(ov_w[1]), .out_rdy(out_rdy), .out_sat(sat_w[1]));
  mvu_pe_acc #(.SF(SF), .TDstI(4), .TAcc(5), .SIGNED(1)) u_s5 (
    .clock(clock), .reset(reset), .in_add(in_add), .in_v(in_v), .in_rdy(rdy_w[2]),
    .clear(clear), .out_acc(acc_s5), .out_v(ov_w[2]), .out_rdy(out_rdy), .out_sat(sat_w[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] act_acc(input int k);
    case (k)
      0:       return 32'(acc_s8);
      1:       return 32'(acc_u8);
      default: return 32'(acc_s5);
    endcase
  endfunction

  function automatic int wd(input int k);
    return (k == 2) ? 5 : 8;
  endfunction

  function automatic bit sg(input int k);
    return k != 1;
  endfunction

  // Reference model: collect a whole group, then evaluate it with integer arithmetic.
  int gv [3][SF];
  int gn [3];
  bit mov [3];
  int macc [3];
  bit msat [3];

  function automatic void grp_eval(input int k, output int val, output bit sat);
    int a, x, hi, lo, w;
    w  = wd(k);
    hi = sg(k) ? (2 ** (w - 1)) - 1 : (2 ** w) - 1;
    lo = sg(k) ? -(2 ** (w - 1)) : 0;
    a = 0;
    sat = 1'b0;
    for (int i = 0; i < SF; i++) begin
      x = gv[k][i];
      if (sg(k) && x >= 8) x -= 16;
      a += x;
      if (SAT && a > hi) begin a = hi; sat = 1'b1; end
      if (SAT && a < lo) begin a = lo; sat = 1'b1; end
    end
    val = a & ((1 << w) - 1);
  endfunction

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        chk($sformatf("mon%0d_rst_v", k), 32'(ov_w[k]), 0);
        gn[k] = 0; mov[k] = 0; macc[k] = 0; msat[k] = 0;
      end else begin
        bit er;
        int v;
        bit s;
        er = !(gn[k] == SF - 1 && mov[k] && !out_rdy);
        chk($sformatf("mon%0d_in_rdy", k), 32'(rdy_w[k]), 32'(er));
        chk($sformatf("mon%0d_out_v", k), 32'(ov_w[k]), 32'(mov[k]));
        if (mov[k]) begin
          chk($sformatf("mon%0d_out_acc", k), act_acc(k), 32'(macc[k]));
          chk($sformatf("mon%0d_out_sat", k), 32'(sat_w[k]), 32'(msat[k]));
        end
        if (mov[k] && out_rdy) mov[k] = 0;
        if (clear) gn[k] = 0;
        if (in_v && er) begin
          gv[k][gn[k]] = int'(in_add);
          gn[k]++;
          if (gn[k] == SF) begin
            grp_eval(k, v, s);
            mov[k] = 1; macc[k] = v; msat[k] = s; gn[k] = 0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    int e_s8, e_u8, e_s5w, e_s5s;
    bit s5sat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk_all(input string nm, input int e_s8, input int e_u8, input int e_s5, input bit s5);
    chk({nm, "_v_s8"}, 32'(ov_w[0]), 1);
    chk({nm, "_v_u8"}, 32'(ov_w[1]), 1);
    chk({nm, "_v_s5"}, 32'(ov_w[2]), 1);
    chk({nm, "_acc_s8"}, 32'(acc_s8), 32'(e_s8));
    chk({nm, "_acc_u8"}, 32'(acc_u8), 32'(e_u8));
    chk({nm, "_acc_s5"}, 32'(acc_s5), 32'(e_s5));
    chk({nm, "_sat_s8"}, 32'(sat_w[0]), 0);
    chk({nm, "_sat_s5"}, 32'(sat_w[2]), 32'(s5));
  endtask

  initial begin
    tbl[0] = '{16'h4321, 10, 10, 10, 10, 1'b0};
    tbl[1] = '{16'hFFFF, 252, 60, 28, 28, 1'b0};
    tbl[2] = '{16'h7777, 28, 28, 28, 15, 1'b1};
    tbl[3] = '{16'h8888, 224, 32, 0, 16, 1'b1};
    tbl[4] = '{16'h0000, 0, 0, 0, 0, 1'b0};
    tbl[5] = '{16'h8F17, 255, 31, 31, 31, 1'b0};

    reset = 1'b1; in_v = 1'b0; in_add = '0; clear = 1'b0; out_rdy = 1'b1;
    step(); step();
    chk("rst_out_v", 32'(ov_w), 0);
    chk("rst_out_sat", 32'(sat_w), 0);
    chk("rst_acc_s8", 32'(acc_s8), 0);
    chk("rst_acc_s5", 32'(acc_s5), 0);
    chk("rst_in_rdy", 32'(rdy_w), 32'h7);
    reset = 1'b0;
    step();

    for (int t = 0; t < 6; t++) begin
      logic [15:0] a;
      a = tbl[t].a;
      for (int j = 0; j < SF; j++) begin
        in_v = 1'b1; in_add = a[4*j +: 4];
        step();
      end
      in_v = 1'b0;
      chk_all($sformatf("tbl%0d", t), tbl[t].e_s8, tbl[t].e_u8,
              SAT ? tbl[t].e_s5s : tbl[t].e_s5w, SAT ? tbl[t].s5sat : 1'b0);
      step();
      chk($sformatf("tbl%0d_v_drop", t), 32'(ov_w), 0);
    end

    // Backpressure: second group's last input stalls until the first result drains.
    out_rdy = 1'b0;
    foreach (tbl[0].a[i]) begin end
    for (int j = 0; j < 7; j++) begin
      in_v = 1'b1; in_add = (j < 4) ? 4'(j + 1) : 4'd1;
      step();
    end
    in_add = 4'd1;
    chk("bp_stall_rdy", 32'(rdy_w), 0);
    step();
    chk("bp_stall_rdy2", 32'(rdy_w), 0);
    chk_all("bp_hold", 10, 10, 10, 1'b0);
    out_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(rdy_w), 32'h7);
    step();
    in_v = 1'b0;
    chk_all("bp_next", 4, 4, 4, 1'b0);
    step();
    chk("bp_drain", 32'(ov_w), 0);

    // Clear alone, then clear coincident with the first element of a group.
    in_v = 1'b1; in_add = 4'd5;
    step(); step();
    in_v = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    for (int j = 0; j < 4; j++) begin in_v = 1'b1; in_add = 4'd1; step(); end
    in_v = 1'b0;
    chk_all("clr", 4, 4, 4, 1'b0);
    in_v = 1'b1; in_add = 4'd7; step();
    in_add = 4'd2; clear = 1'b1; step();
    clear = 1'b0;
    for (int j = 0; j < 3; j++) begin in_add = 4'd1; step(); end
    in_v = 1'b0;
    chk_all("clr_acc", 5, 5, 5, 1'b0);
    step();

    // Asynchronous reset in the middle of a cycle with a result pending and a partial group.
    out_rdy = 1'b0;
    for (int j = 0; j < 4; j++) begin in_v = 1'b1; in_add = 4'd1; step(); end
    in_add = 4'd3; step(); step();
    in_v = 1'b0;
    chk("mid_pending", 32'(ov_w), 32'h7);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_v", 32'(ov_w), 0);
    chk("mid_rst_acc", 32'(acc_s8), 0);
    step();
    reset = 1'b0; out_rdy = 1'b1;
    step();
    for (int j = 0; j < 4; j++) begin in_v = 1'b1; in_add = 4'(j + 1); step(); end
    in_v = 1'b0;
    chk_all("post_rst", 10, 10, 10, 1'b0);

    for (int c = 0; c < 400; c++) begin
      in_v    = ($urandom % 4) != 0;
      in_add  = 4'($urandom);
      clear   = ($urandom % 16) == 0;
      out_rdy = ($urandom % 3) != 0;
      step();
    end
    in_v = 1'b0; clear = 1'b0; out_rdy = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
